// File: rtl/sivers_spi_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sivers_spi_ctrl
// Description : SPI master (mode 0, MSB first) that serialises a single
//               {rw, addr, data} command from the GPIO register slice to the
//               Sivers mmWave RFIC. It returns the last DATA_W MISO bits of
//               the frame together with a one-cycle done pulse.
// Ports       : ACLK/ARESET         - clock, synchronous active-high reset
//               cmd_valid/cmd_ready - command handshake
//               cmd_rw/addr/wdata   - command fields (latched at handshake)
//               rsp_valid/rsp_rdata - end-of-frame pulse, captured byte
//               busy                - high whenever the controller is not idle
//               spi_cs_n/sclk/mosi  - SPI outputs; spi_miso - SPI input
// Revision    : 1.0 - initial release
// ============================================================================
module sivers_spi_ctrl #(
    parameter int CLK_DIV  = 2,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rw,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              spi_cs_n,
    output logic              spi_sclk,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int T_MAX0  = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int TMR_MAX = (T_MAX0 > CS_HOLD) ? T_MAX0 : CS_HOLD;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int BIT_W   = $clog2(FRAME_W);

    localparam logic [TMR_W-1:0] HALF_LAST  = TMR_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0] SETUP_LAST = TMR_W'(CS_SETUP - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(CS_HOLD - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_W - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic [TMR_W-1:0]   r_tmr;      // cycles spent in SETUP/HOLD, or in the current SCLK half
    logic               r_phase;    // SCLK level during SHIFT
    logic [BIT_W-1:0]   r_bit;      // index of the bit currently on MOSI
    logic [FRAME_W-1:0] r_shift;
    logic [DATA_W-1:0]  r_rx;

    logic w_accept;
    logic w_half_end;
    logic w_rise;
    logic w_fall;

    assign w_accept   = (r_state == S_IDLE) && cmd_valid;
    assign w_half_end = (r_state == S_SHIFT) && (r_tmr == HALF_LAST);
    // A half-period ending while SCLK is low makes SCLK rise, and vice versa.
    assign w_rise     = w_half_end && !r_phase;
    assign w_fall     = w_half_end && r_phase;

    // State register
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (cmd_valid)             w_state_next = S_SETUP;
            S_SETUP: if (r_tmr == SETUP_LAST)   w_state_next = S_SHIFT;
            S_SHIFT: if (w_fall && (r_bit == BIT_LAST)) w_state_next = S_HOLD;
            S_HOLD:  if (r_tmr == HOLD_LAST)    w_state_next = S_DONE;
            S_DONE:                             w_state_next = S_IDLE;
            default:                            w_state_next = S_IDLE;
        endcase
    end

    // Datapath: timers, shift registers and the response latch
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_tmr     <= '0;
            r_phase   <= 1'b0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_rx      <= '0;
            rsp_rdata <= '0;
        end else begin
            if ((w_state_next != r_state) || w_half_end) begin
                r_tmr <= '0;
            end else if (r_state != S_IDLE) begin
                r_tmr <= r_tmr + TMR_W'(1);
            end

            if (r_state != S_SHIFT) begin
                r_phase <= 1'b0;
            end else if (w_half_end) begin
                r_phase <= ~r_phase;
            end

            if (r_state != S_SHIFT) begin
                r_bit <= '0;
            end else if (w_fall) begin
                r_bit <= (r_bit == BIT_LAST) ? '0 : r_bit + BIT_W'(1);
            end

            // Read frames carry zeros in the MOSI data field.
            if (w_accept) begin
                r_shift <= {cmd_rw, cmd_addr, (cmd_rw ? {DATA_W{1'b0}} : cmd_wdata)};
            end else if (w_fall) begin
                r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
            end

            // MISO enters at the LSB; truncation drops the oldest bit.
            if (w_rise) begin
                r_rx <= DATA_W'({r_rx, spi_miso});
            end

            if ((r_state == S_HOLD) && (w_state_next == S_DONE)) begin
                rsp_rdata <= r_rx;
            end
        end
    end

    // Output decode
    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b1;
        rsp_valid = 1'b0;
        spi_cs_n  = 1'b1;
        spi_sclk  = 1'b0;
        spi_mosi  = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            S_SETUP: begin
                spi_cs_n = 1'b0;
                spi_mosi = r_shift[FRAME_W-1];
            end
            S_SHIFT: begin
                spi_cs_n = 1'b0;
                spi_sclk = r_phase;
                spi_mosi = r_shift[FRAME_W-1];
            end
            S_HOLD: begin
                spi_cs_n = 1'b0;
            end
            S_DONE: begin
                rsp_valid = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_sivers_spi_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sivers_spi_ctrl
// Description : Self-checking bench for sivers_spi_ctrl. A default-parameter
//               instance and a fast instance (CLK_DIV=1, CS_SETUP=1,
//               CS_HOLD=1) are driven by directed and random commands; a
//               slave model answers on MISO and the observed frames, cycle
//               timing and returned bytes are compared with expectations
//               derived from the frame format and latency formula.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sivers_spi_ctrl;

    localparam int F        = 25;
    localparam int LAT      = 2 + 2 * 2 * F + 2 + 1;
    localparam int LAT_FAST = 1 + 2 * 1 * F + 1 + 1;

    logic ACLK = 1'b0;
    logic ARESET = 1'b1;
    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    // Default instance
    logic        cmd_valid = 1'b0, cmd_ready, cmd_rw = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [7:0]  cmd_wdata = '0, rsp_rdata;
    logic        rsp_valid, busy, spi_cs_n, spi_sclk, spi_mosi;
    logic        spi_miso = 1'b0;

    sivers_spi_ctrl dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso)
    );

    // Fast instance
    logic        f_cmd_valid = 1'b0, f_cmd_ready, f_cmd_rw = 1'b0;
    logic [15:0] f_cmd_addr = '0;
    logic [7:0]  f_cmd_wdata = '0, f_rsp_rdata;
    logic        f_rsp_valid, f_busy, f_spi_cs_n, f_spi_sclk, f_spi_mosi;
    logic        f_spi_miso = 1'b0;

    sivers_spi_ctrl #(.CLK_DIV(1), .ADDR_W(16), .DATA_W(8), .CS_SETUP(1), .CS_HOLD(1)) dut_fast (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(f_cmd_valid), .cmd_ready(f_cmd_ready), .cmd_rw(f_cmd_rw),
        .cmd_addr(f_cmd_addr), .cmd_wdata(f_cmd_wdata),
        .rsp_valid(f_rsp_valid), .rsp_rdata(f_rsp_rdata), .busy(f_busy),
        .spi_cs_n(f_spi_cs_n), .spi_sclk(f_spi_sclk), .spi_mosi(f_spi_mosi),
        .spi_miso(f_spi_miso)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Observation queues for the default instance
    int          hs_q[$], cs_fall_q[$], cs_rise_q[$], rsp_q[$], nrise_q[$];
    logic [F-1:0] mosi_q[$], slave_q[$], exp_frame_q[$];
    logic [7:0]  rd_q[$], exp_rd_q[$];

    logic         prev_cs = 1'b1, prev_sclk = 1'b0;
    logic [F-1:0] cur_slave = '0, mosi_bits = '0;
    int           miso_idx = 0, nrise = 0;

    // Monitor + slave model (mode 0: slave presents a bit on CS fall and after each SCLK fall)
    always @(negedge ACLK) begin
        if (cmd_valid && cmd_ready) hs_q.push_back(cyc);
        if (prev_cs && !spi_cs_n) begin
            cs_fall_q.push_back(cyc);
            if (slave_q.size() > 0) cur_slave = slave_q.pop_front();
            else                    cur_slave = F'($urandom);
            miso_idx  = 0;
            spi_miso  = cur_slave[F-1];
            mosi_bits = '0;
            nrise     = 0;
        end
        if (!prev_sclk && spi_sclk) begin
            mosi_bits = {mosi_bits[F-2:0], spi_mosi};
            nrise++;
        end
        if (prev_sclk && !spi_sclk) begin
            miso_idx++;
            spi_miso = (miso_idx < F) ? cur_slave[F-1-miso_idx] : 1'b0;
        end
        if (!prev_cs && spi_cs_n) begin
            cs_rise_q.push_back(cyc);
            mosi_q.push_back(mosi_bits);
            nrise_q.push_back(nrise);
        end
        if (rsp_valid) begin
            rsp_q.push_back(cyc);
            rd_q.push_back(rsp_rdata);
        end
        prev_cs   = spi_cs_n;
        prev_sclk = spi_sclk;
    end

    // Monitor + slave model for the fast instance
    logic         f_prev_cs = 1'b1, f_prev_sclk = 1'b0;
    logic [F-1:0] f_slave = '0, f_bits = '0;
    int           f_idx = 0, f_nrise = 0, f_hs = 0, f_rsp = 0, f_rsp_n = 0;
    logic [7:0]   f_rd = '0;

    always @(negedge ACLK) begin
        if (f_cmd_valid && f_cmd_ready) f_hs = cyc;
        if (f_prev_cs && !f_spi_cs_n) begin
            f_idx      = 0;
            f_spi_miso = f_slave[F-1];
            f_bits     = '0;
            f_nrise    = 0;
        end
        if (!f_prev_sclk && f_spi_sclk) begin
            f_bits = {f_bits[F-2:0], f_spi_mosi};
            f_nrise++;
        end
        if (f_prev_sclk && !f_spi_sclk) begin
            f_idx++;
            f_spi_miso = (f_idx < F) ? f_slave[F-1-f_idx] : 1'b0;
        end
        if (f_rsp_valid) begin
            f_rsp = cyc;
            f_rd  = f_rsp_rdata;
            f_rsp_n++;
        end
        f_prev_cs   = f_spi_cs_n;
        f_prev_sclk = f_spi_sclk;
    end

    function automatic logic [F-1:0] exp_frame(input logic rw, input logic [15:0] a, input logic [7:0] d);
        return {rw, a, (rw ? 8'h00 : d)};
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic miss(input string tag);
        n_cmp++;
        n_err++;
        $error("FAIL %s: observed missing/timeout expected event", tag);
    endtask

    task automatic send(input logic rw, input logic [15:0] a, input logic [7:0] d, input logic [F-1:0] sw);
        int b;
        slave_q.push_back(sw);
        exp_frame_q.push_back(exp_frame(rw, a, d));
        exp_rd_q.push_back(sw[7:0]);
        cmd_rw = rw; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        b = 0;
        do begin tick(); b++; end while (!busy && b < 50);
        if (!busy) miss("accept");
        cmd_valid = 1'b0;
        // Scramble the command inputs once the frame is shifting.
        repeat (20) tick();
        cmd_rw = 1'($urandom); cmd_addr = 16'($urandom); cmd_wdata = 8'($urandom);
    endtask

    task automatic wait_rsp(input int n);
        int b;
        b = 0;
        while (rsp_q.size() < n && b < 1000) begin tick(); b++; end
        if (rsp_q.size() < n) miss("rsp_timeout");
        tick();
    endtask

    task automatic check_frame(input string tag, input int lat);
        int hs, rs, cf, cr;
        if (hs_q.size() == 0 || rsp_q.size() == 0 || mosi_q.size() == 0 || rd_q.size() == 0 ||
            cs_fall_q.size() == 0 || cs_rise_q.size() == 0 || exp_frame_q.size() == 0 ||
            exp_rd_q.size() == 0 || nrise_q.size() == 0) begin
            miss({tag, "_frame"});
            return;
        end
        hs = hs_q.pop_front();
        rs = rsp_q.pop_front();
        cf = cs_fall_q.pop_front();
        cr = cs_rise_q.pop_front();
        chk({tag, "_mosi"},    32'(mosi_q.pop_front()), 32'(exp_frame_q.pop_front()));
        chk({tag, "_nrise"},   nrise_q.pop_front(), F);
        chk({tag, "_rdata"},   32'(rd_q.pop_front()), 32'(exp_rd_q.pop_front()));
        chk({tag, "_latency"}, rs - hs, lat);
        chk({tag, "_csfall"},  cf - hs, 1);
        chk({tag, "_csrise"},  cr - hs, lat);
    endtask

    logic [F-1:0] sw;
    int           b;
    int           h0, h1;

    initial begin
        // 1a: reset state
        ARESET = 1'b1;
        repeat (3) tick();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy",      busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_cs_n",      spi_cs_n, 1);
        chk("rst_sclk",      spi_sclk, 0);
        chk("rst_mosi",      spi_mosi, 0);
        ARESET = 1'b0;
        tick();

        // 1b: reset in the middle of a frame
        slave_q.push_back(F'($urandom));
        cmd_rw = 1'b0; cmd_addr = 16'hBEEF; cmd_wdata = 8'h5A; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        repeat (30) tick();
        chk("abort_busy_before", busy, 1);
        ARESET = 1'b1;
        tick();
        chk("abort_cs_n",      spi_cs_n, 1);
        chk("abort_sclk",      spi_sclk, 0);
        chk("abort_cmd_ready", cmd_ready, 1);
        repeat (2) tick();
        ARESET = 1'b0;
        repeat (150) tick();
        chk("abort_no_rsp", rsp_q.size(), 0);
        hs_q.delete(); cs_fall_q.delete(); cs_rise_q.delete(); rsp_q.delete();
        nrise_q.delete(); mosi_q.delete(); rd_q.delete(); slave_q.delete();

        // 2: write
        send(1'b0, 16'h1234, 8'hA5, F'($urandom));
        wait_rsp(1);
        check_frame("write", LAT);

        // 3: read, slave returns 0x3C in the data field
        sw = F'($urandom);
        sw[7:0] = 8'h3C;
        send(1'b1, 16'h0042, 8'hFF, sw);
        wait_rsp(1);
        check_frame("read", LAT);
        repeat (10) tick();
        chk("read_hold", rsp_rdata, 8'h3C);

        // 4: back-to-back with cmd_valid held high
        slave_q.push_back(F'($urandom));
        slave_q.push_back(F'($urandom));
        exp_rd_q.push_back(slave_q[0][7:0]);
        exp_rd_q.push_back(slave_q[1][7:0]);
        exp_frame_q.push_back(exp_frame(1'b0, 16'hC0DE, 8'h81));
        exp_frame_q.push_back(exp_frame(1'b1, 16'h7E01, 8'h42));
        cmd_rw = 1'b0; cmd_addr = 16'hC0DE; cmd_wdata = 8'h81; cmd_valid = 1'b1;
        tick();
        cmd_rw = 1'b1; cmd_addr = 16'h7E01; cmd_wdata = 8'h42;
        b = 0;
        while (hs_q.size() < 2 && b < 300) begin tick(); b++; end
        cmd_valid = 1'b0;
        wait_rsp(2);
        if (hs_q.size() >= 2 && cs_rise_q.size() >= 1 && cs_fall_q.size() >= 2) begin
            h0 = hs_q[0];
            h1 = hs_q[1];
            chk("b2b_second_hs", h1 - h0, LAT + 1);
            chk("b2b_cs_rise",   cs_rise_q[0] - h0, LAT);
            chk("b2b_cs_fall2",  cs_fall_q[1] - h0, LAT + 2);
        end else begin
            miss("b2b_handshakes");
        end
        check_frame("b2b_first", LAT);
        check_frame("b2b_second", LAT);

        // 5: random commands, inputs scrambled mid-frame
        for (int i = 0; i < 6; i++) begin
            send(1'($urandom), 16'($urandom), 8'($urandom), F'($urandom));
            wait_rsp(1);
            check_frame("random", LAT);
        end

        // 6: fast instance
        for (int i = 0; i < 2; i++) begin
            logic        rw;
            logic [15:0] a;
            logic [7:0]  d;
            int          n0;
            rw = (i == 1);
            a  = 16'($urandom);
            d  = 8'($urandom);
            f_slave = F'($urandom);
            n0 = f_rsp_n;
            f_cmd_rw = rw; f_cmd_addr = a; f_cmd_wdata = d; f_cmd_valid = 1'b1;
            tick();
            f_cmd_valid = 1'b0;
            f_cmd_addr = 16'($urandom); f_cmd_wdata = 8'($urandom);
            b = 0;
            while (f_rsp_n == n0 && b < 200) begin tick(); b++; end
            if (f_rsp_n == n0) begin
                miss("fast_rsp_timeout");
            end else begin
                chk("fast_latency", f_rsp - f_hs, LAT_FAST);
                chk("fast_mosi",    32'(f_bits), 32'(exp_frame(rw, a, d)));
                chk("fast_nrise",   f_nrise, F);
                chk("fast_rdata",   f_rd, f_slave[7:0]);
            end
            repeat (3) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no completion expected $finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
